// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: pixel word width, default channel count, signed max helper.
// Pure declarations, no logic and no latency of its own.
// Backpressure: not applicable.
package cnn_pkg;

    localparam int DW = 16;
    localparam int CH = 4;

    typedef logic signed [DW-1:0] pixel_t;

    // Both operands are signed, so this is a two's-complement compare.
    // On a tie either operand is correct; b is returned.
    function automatic pixel_t max2(input pixel_t a, input pixel_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer for one row of horizontal maxima: one write port, one read port.
// Latency: write lands on the next clock edge; read is combinational.
// Backpressure: none, the caller qualifies writes with its own handshake.
//
// Ports:
//   clk        - rising-edge clock
//   i_wr_vld   - write enable
//   i_wr_addr  - write address
//   i_wr_dat   - write data
//   i_rd_addr  - read address
//   o_rd_dat   - read data (asynchronous)
module pool_line_buf #(
    parameter  int DEPTH = 13,
    parameter  int WIDTH = 64,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             i_wr_vld,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_dat,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_dat
);

    // Contents are deliberately not reset: every entry is rewritten on the
    // even row before the odd row reads it.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_vld) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 max pooling over a raster-order multi-channel feature map.
// Latency: one cycle from the accept of the bottom-right window pixel to valid_out.
// Backpressure: ready = !valid_out || out_ready; the output register holds while stalled.
//
// Ports:
//   clk, reset          - clock, synchronous active-low reset
//   pixel_in, valid_in  - input beat (one pixel of every channel)
//   ready               - input beat is accepted when valid_in && ready
//   pixel_out, valid_out, last_out - pooled pixel, its valid, end-of-frame flag
//   out_ready           - downstream accepts pixel_out this cycle
module max_pool_2x2
    import cnn_pkg::*;
#(
    parameter int IMG_W = 26,
    parameter int IMG_H = 26,
    parameter int CH    = cnn_pkg::CH
) (
    input  logic   clk,
    input  logic   reset,
    input  pixel_t pixel_in [0:CH-1],
    input  logic   valid_in,
    output logic   ready,
    output pixel_t pixel_out [0:CH-1],
    output logic   valid_out,
    input  logic   out_ready,
    output logic   last_out
);

    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int LB_D  = IMG_W / 2;
    localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;

    if ((IMG_W % 2) != 0 || IMG_W < 2 || (IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_geometry
        $error("max_pool_2x2: IMG_W and IMG_H must be even and at least 2");
    end

    logic [CW-1:0]      r_col;
    logic [RW-1:0]      r_row;
    logic               r_valid_out;
    logic               r_last_out;
    pixel_t             r_pixel_out [0:CH-1];
    pixel_t             r_pair      [0:CH-1];

    logic               w_accept;
    logic               w_col_end;
    logic               w_row_end;
    logic               w_load;
    logic               w_lb_we;
    logic [LB_AW-1:0]   w_lb_addr;
    logic [CH*DW-1:0]   w_lb_wdat;
    logic [CH*DW-1:0]   w_lb_rdat;
    pixel_t             w_h   [0:CH-1];
    pixel_t             w_win [0:CH-1];

    assign ready     = !r_valid_out || out_ready;
    assign w_accept  = valid_in && ready;
    assign w_col_end = (r_col == CW'(IMG_W - 1));
    assign w_row_end = (r_row == RW'(IMG_H - 1));

    // Odd column closes a horizontal pair; the row parity then decides whether
    // the pair max is parked in the line buffer or finishes a 2x2 window.
    assign w_lb_we   = w_accept && r_col[0] && !r_row[0];
    assign w_load    = w_accept && r_col[0] &&  r_row[0];
    assign w_lb_addr = LB_AW'(r_col >> 1);

    always_comb begin
        w_lb_wdat = '0;
        for (int c = 0; c < CH; c++) begin
            w_h[c]                 = max2(r_pair[c], pixel_in[c]);
            w_win[c]               = max2(pixel_t'(w_lb_rdat[c*DW +: DW]), w_h[c]);
            w_lb_wdat[c*DW +: DW]  = w_h[c];
        end
    end

    pool_line_buf #(
        .DEPTH (LB_D),
        .WIDTH (CH*DW)
    ) u_line_buf (
        .clk       (clk),
        .i_wr_vld  (w_lb_we),
        .i_wr_addr (w_lb_addr),
        .i_wr_dat  (w_lb_wdat),
        .i_rd_addr (w_lb_addr),
        .o_rd_dat  (w_lb_rdat)
    );

    // Raster position; wraps straight into the next frame with no idle cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Even-column pixel waiting for its odd-column partner; not reset.
    always_ff @(posedge clk) begin
        if (w_accept && !r_col[0]) begin
            r_pair <= pixel_in;
        end
    end

    // A load can only happen when ready is high, so it never overwrites a
    // stalled result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid_out <= 1'b0;
            r_last_out  <= 1'b0;
            for (int c = 0; c < CH; c++) begin
                r_pixel_out[c] <= '0;
            end
        end else if (w_load) begin
            r_valid_out <= 1'b1;
            r_last_out  <= w_row_end && w_col_end;
            r_pixel_out <= w_win;
        end else if (out_ready) begin
            r_valid_out <= 1'b0;
            r_last_out  <= 1'b0;
        end
    end

    assign pixel_out = r_pixel_out;
    assign valid_out = r_valid_out;
    assign last_out  = r_last_out;

endmodule

// File: tb/tb_max_pool_2x2.sv
`timescale 1ns/1ps
module tb_max_pool_2x2;
    import cnn_pkg::*;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int NC = 4;
    localparam int NPIX = W * H;

    logic   clk = 1'b0;
    logic   reset;
    logic   valid_in;
    logic   ready;
    logic   valid_out;
    logic   out_ready;
    logic   last_out;
    pixel_t pixel_in  [0:NC-1];
    pixel_t pixel_out [0:NC-1];

    always #5 clk = ~clk;

    max_pool_2x2 #(.IMG_W(W), .IMG_H(H), .CH(NC)) dut (
        .clk       (clk),
        .reset     (reset),
        .pixel_in  (pixel_in),
        .valid_in  (valid_in),
        .ready     (ready),
        .pixel_out (pixel_out),
        .valid_out (valid_out),
        .out_ready (out_ready),
        .last_out  (last_out)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Keeps the whole frame as a 2D array; an output is the plain max of the
    // four frame pixels of the window, due one cycle after its last pixel.
    bit m_known = 0;
    bit m_valid = 0;
    bit m_last  = 0;
    int m_val [NC];
    int m_idx = 0;
    int fb [H][W][NC];

    int cap_c0[$];
    int cap_c2[$];
    int cap_last[$];

    always @(negedge clk) begin
        bit acc;
        int r, c, mx;
        if (m_known) begin
            chk("valid_out", int'(valid_out), int'(m_valid));
            chk("ready", int'(ready), int'(!m_valid || out_ready));
            for (int ch = 0; ch < NC; ch++) chk($sformatf("pixel_out[%0d]", ch), int'(pixel_out[ch]), m_val[ch]);
            if (m_valid) chk("last_out", int'(last_out), int'(m_last));
        end
        if (valid_out === 1'b1 && out_ready === 1'b1) begin
            cap_c0.push_back(int'(pixel_out[0]));
            cap_c2.push_back(int'(pixel_out[2]));
            cap_last.push_back(int'(last_out));
        end
        if (reset === 1'b0) begin
            m_known = 1;
            m_valid = 0;
            m_last  = 0;
            m_idx   = 0;
            for (int ch = 0; ch < NC; ch++) m_val[ch] = 0;
        end else if (m_known) begin
            acc = valid_in && (!m_valid || out_ready);
            if (acc) begin
                r = m_idx / W;
                c = m_idx % W;
                for (int ch = 0; ch < NC; ch++) fb[r][c][ch] = int'(pixel_in[ch]);
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    for (int ch = 0; ch < NC; ch++) begin
                        mx = -100000;
                        for (int dr = 0; dr < 2; dr++)
                            for (int dc = 0; dc < 2; dc++)
                                if (fb[r-dr][c-dc][ch] > mx) mx = fb[r-dr][c-dc][ch];
                        m_val[ch] = mx;
                    end
                    m_valid = 1;
                    m_last  = (m_idx == NPIX - 1);
                end else if (out_ready) begin
                    m_valid = 0;
                end
                m_idx = (m_idx + 1) % NPIX;
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    int negpos [4];
    int rnd [NPIX][NC];

    function automatic int pix_val(input int kind, input int idx, input int ch);
        int r, c, win, pos;
        r = idx / W;
        c = idx % W;
        case (kind)
            1: begin
                win = (r / 2) * (W / 2) + c / 2;
                pos = (r % 2) * 2 + c % 2;
                return (pos == negpos[win]) ? -32768 : -5;
            end
            2: return (ch == 2) ? -(idx + 1) : idx + 1;
            3: return rnd[idx][ch];
            default: return idx + 1;
        endcase
    endfunction

    // Sends nbeats beats (frame-relative index wraps every frame). After beat
    // stall_at is accepted, out_ready is held low for three cycles.
    task automatic run_beats(input int kind, input int nbeats, input int stall_at, input bit rnd_hs);
        int n = 0;
        int st = 0;
        int guard = 0;
        bit acc;
        while (n < nbeats && guard < 2000) begin
            for (int ch = 0; ch < NC; ch++) pixel_in[ch] = pixel_t'(pix_val(kind, n % NPIX, ch));
            valid_in  = rnd_hs ? ($urandom_range(0, 3) != 0) : 1'b1;
            out_ready = (st > 0) ? 1'b0 : (rnd_hs ? ($urandom_range(0, 2) != 0) : 1'b1);
            @(negedge clk);
            acc = valid_in && ready;
            @(posedge clk);
            #1;
            if (st > 0) st--;
            if (acc) begin
                if (n == stall_at) st = 3;
                n++;
            end
            guard++;
        end
        chk("beats_accepted_within_budget", n, nbeats);
        valid_in  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic drain();
        valid_in  = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_caps();
        cap_c0.delete();
        cap_c2.delete();
        cap_last.delete();
    endtask

    task automatic chk_list(input string name, input int q[$], input int e[4], input int reps);
        int act;
        chk({name, "_count"}, q.size(), 4 * reps);
        for (int i = 0; i < 4 * reps; i++) begin
            act = (i < q.size()) ? q[i] : 99999;
            chk($sformatf("%s[%0d]", name, i), act, e[i % 4]);
        end
    endtask

    int e_seq  [4] = '{6, 8, 14, 16};
    int e_last [4] = '{0, 0, 0, 1};
    int e_neg  [4] = '{-5, -5, -5, -5};
    int e_ch2  [4] = '{-1, -3, -9, -11};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        valid_in  = 1'b0;
        out_ready = 1'b1;
        for (int ch = 0; ch < NC; ch++) pixel_in[ch] = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset state, first cycle after release.
        @(negedge clk);
        chk("reset_valid_out", int'(valid_out), 0);
        chk("reset_last_out", int'(last_out), 0);
        chk("reset_ready", int'(ready), 1);
        chk("reset_pixel_out0", int'(pixel_out[0]), 0);
        @(posedge clk);
        #1;

        // Ascending frame.
        clear_caps();
        run_beats(0, NPIX, -1, 0);
        drain();
        chk_list("seq_c0", cap_c0, e_seq, 1);
        chk_list("seq_last", cap_last, e_last, 1);

        // Negative frame with one most-negative pixel per window.
        for (int i = 0; i < 4; i++) negpos[i] = $urandom_range(0, 3);
        clear_caps();
        run_beats(1, NPIX, -1, 0);
        drain();
        chk_list("neg_c0", cap_c0, e_neg, 1);
        chk_list("neg_c2", cap_c2, e_neg, 1);

        // Channel 2 negated.
        clear_caps();
        run_beats(2, NPIX, -1, 0);
        drain();
        chk_list("ch2_c0", cap_c0, e_seq, 1);
        chk_list("ch2_c2", cap_c2, e_ch2, 1);

        // Downstream stall while the second output is valid.
        clear_caps();
        run_beats(0, NPIX, 7, 0);
        drain();
        chk_list("stall_c0", cap_c0, e_seq, 1);

        // Two back-to-back frames.
        clear_caps();
        run_beats(0, 2 * NPIX, -1, 0);
        drain();
        chk_list("b2b_c0", cap_c0, e_seq, 2);
        chk_list("b2b_last", cap_last, e_last, 2);

        // Reset in the middle of a frame, then a full frame.
        run_beats(0, 6, -1, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        clear_caps();
        run_beats(0, NPIX, -1, 0);
        drain();
        chk_list("post_reset_c0", cap_c0, e_seq, 1);

        // Random data with random valid_in gaps and out_ready stalls.
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < NPIX; i++)
                for (int ch = 0; ch < NC; ch++)
                    rnd[i][ch] = int'($signed(16'($urandom)));
            run_beats(3, NPIX, -1, 1);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
